// File: rtl/tl_sink_if.sv
// tl_sink_if -- bundle of egress-FIFO, output and counter-readout signals
// for the tl_sink block.
//
// Optional feature macro: TL_SINK_CLASS_CHK_EN adds the err flag.
//
// Signals (direction as seen by the sink, modport slave):
//   data_in0..3  in  12  FIFO read data, valid the cycle after the pop
//   empty0..3    in   1  FIFO empty flags
//   pop0..3      out  1  FIFO read strobes, one-hot or zero
//   init         in   1  clear-and-hold request
//   stall        in   1  blocks issue of new pops
//   data_out     out 12  captured word
//   valid        out  1  data_out qualifier
//   chan         out  2  source channel of data_out
//   req          in   1  counter read request
//   idx          in   2  counter select
//   contador     out  5  counter readout
//   cnt_valid    out  1  contador qualifier
//   idle         out  1  sink drained and quiescent
//   err          out  1  sticky class mismatch (TL_SINK_CLASS_CHK_EN only)
interface tl_sink_if;
  logic [11:0] data_in0, data_in1, data_in2, data_in3;
  logic        empty0, empty1, empty2, empty3;
  logic        pop0, pop1, pop2, pop3;
  logic        init;
  logic        stall;
  logic [11:0] data_out;
  logic        valid;
  logic [1:0]  chan;
  logic        req;
  logic [1:0]  idx;
  logic [4:0]  contador;
  logic        cnt_valid;
  logic        idle;
`ifdef TL_SINK_CLASS_CHK_EN
  logic        err;
`endif

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3,
    input  empty0, empty1, empty2, empty3,
    input  init, stall, req, idx,
`ifdef TL_SINK_CLASS_CHK_EN
    output err,
`endif
    output pop0, pop1, pop2, pop3,
    output data_out, valid, chan, contador, cnt_valid, idle
  );

  modport master (
    output data_in0, data_in1, data_in2, data_in3,
    output empty0, empty1, empty2, empty3,
    output init, stall, req, idx,
`ifdef TL_SINK_CLASS_CHK_EN
    input  err,
`endif
    input  pop0, pop1, pop2, pop3,
    input  data_out, valid, chan, contador, cnt_valid, idle
  );
endinterface

// File: rtl/tl_sink.sv
// tl_sink -- drains four egress FIFOs round-robin, one word per cycle,
// presents each word with its channel two cycles after the pop, and keeps
// a saturating 5-bit word counter per channel readable through req/idx.
//
// Optional feature macro: TL_SINK_CLASS_CHK_EN. When defined, a word whose
// data[11:10] differs from its channel raises a sticky err and is not
// counted (it is still delivered on data_out).
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    tl_sink_if.slave (FIFO side, output side, counter readout)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RESET  | held while reset is low; leaves on the first clk edge after
// S_INIT   | counters/pointer cleared, no pops, held while init=1
// S_IDLE   | no pops; waits for a non-empty FIFO with stall=0
// S_ACTIVE | pops one non-empty FIFO per cycle unless stalled
module tl_sink (
  input  logic     clk,
  input  logic     reset,
  tl_sink_if.slave bus
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  empty;
  logic [11:0] din [4];
  logic [3:0]  pop_vec;
  logic [1:0]  pop_ch;
  logic        pop_any;
  logic [1:0]  cand;

  logic        p1_vld_q;
  logic [1:0]  p1_ch_q;
  logic        valid_q;
  logic [11:0] data_out_q;
  logic [1:0]  chan_q;
  logic [4:0]  cnt_q [4];
  logic [4:0]  contador_q;
  logic        cnt_valid_q;

  logic [11:0] din_sel;
  logic        accept;
  logic        count_ok;
  logic        rd_en;

  assign empty = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
  assign din[0] = bus.data_in0;
  assign din[1] = bus.data_in1;
  assign din[2] = bus.data_in2;
  assign din[3] = bus.data_in3;

  // Pop selection and next state. init suppresses any pop in the same cycle
  // so nothing is left in flight when INIT is entered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pop_vec = '0;
    pop_ch  = '0;
    pop_any = 1'b0;
    cand    = '0;

    if (state_q == S_ACTIVE && !bus.stall && !bus.init) begin
      for (int i = 0; i < 4; i++) begin
        cand = ptr_q + 2'(i);
        if (!pop_any && !empty[cand]) begin
          pop_any = 1'b1;
          pop_ch  = cand;
        end
      end
    end

    if (pop_any) begin
      pop_vec[pop_ch] = 1'b1;
      ptr_d           = pop_ch + 2'd1;
    end

    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!bus.init) state_d = S_IDLE;
      S_IDLE:   if (empty != 4'hF && !bus.stall) state_d = S_ACTIVE;
      S_ACTIVE: if (empty == 4'hF && !p1_vld_q) state_d = S_IDLE;
      default:  state_d = S_RESET;
    endcase

    if (bus.init) begin
      state_d = S_INIT;
      ptr_d   = '0;
    end
  end

  // The FIFO word popped last cycle is on din[p1_ch_q] now.
  assign din_sel = din[p1_ch_q];
  assign accept  = p1_vld_q && !bus.init;
  assign rd_en   = bus.req && (state_q != S_RESET);

`ifdef TL_SINK_CLASS_CHK_EN
  logic err_q;
  assign count_ok = (din_sel[11:10] == p1_ch_q);
  assign bus.err  = err_q;
`else
  assign count_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RESET;
      ptr_q       <= '0;
      p1_vld_q    <= 1'b0;
      p1_ch_q     <= '0;
      valid_q     <= 1'b0;
      data_out_q  <= '0;
      chan_q      <= '0;
      contador_q  <= '0;
      cnt_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
`ifdef TL_SINK_CLASS_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      p1_vld_q <= pop_any;
      p1_ch_q  <= pop_ch;
      valid_q  <= accept;
      if (accept) begin
        data_out_q <= din_sel;
        chan_q     <= p1_ch_q;
      end

      // Readout samples the counters before this edge's increment.
      cnt_valid_q <= rd_en;
      if (rd_en) contador_q <= cnt_q[bus.idx];

      for (int i = 0; i < 4; i++) begin
        if (bus.init)
          cnt_q[i] <= '0;
        else if (accept && count_ok && p1_ch_q == 2'(i) && cnt_q[i] != 5'd31)
          cnt_q[i] <= cnt_q[i] + 5'd1;
      end

`ifdef TL_SINK_CLASS_CHK_EN
      if (bus.init)
        err_q <= 1'b0;
      else if (accept && !count_ok)
        err_q <= 1'b1;
`endif
    end
  end

  assign bus.pop0      = pop_vec[0];
  assign bus.pop1      = pop_vec[1];
  assign bus.pop2      = pop_vec[2];
  assign bus.pop3      = pop_vec[3];
  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.chan      = chan_q;
  assign bus.contador  = contador_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.idle      = (state_q == S_IDLE) && !p1_vld_q && !valid_q;

endmodule

// File: tb/tb_tl_sink.sv
// tb_tl_sink -- self-checking bench for tl_sink. Four FIFO models feed the
// sink; every pop pushes the expected word onto a scoreboard that is
// compared when the DUT presents valid. Counter reads come from a table.
module tb_tl_sink;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tl_sink_if bus ();
  tl_sink dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcount = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO models: read data registered on the pop edge.
  logic [11:0] mem [4][256];
  int          head [4];
  int          tail [4];
  logic [11:0] rd_q [4];
  logic [3:0]  pop_v, empty_v;

  assign pop_v   = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
  assign empty_v = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
  assign bus.empty0 = (head[0] == tail[0]);
  assign bus.empty1 = (head[1] == tail[1]);
  assign bus.empty2 = (head[2] == tail[2]);
  assign bus.empty3 = (head[3] == tail[3]);
  assign bus.data_in0 = rd_q[0];
  assign bus.data_in1 = rd_q[1];
  assign bus.data_in2 = rd_q[2];
  assign bus.data_in3 = rd_q[3];

  initial begin
    for (int k = 0; k < 4; k++) begin
      head[k] = 0;
      tail[k] = 0;
      rd_q[k] = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (pop_v[k] && head[k] < 255) begin
        rd_q[k] <= mem[k][head[k]];
        head[k] <= head[k] + 1;
      end
  end

  task automatic load(input int k, input logic [11:0] w);
    mem[k][tail[k]] = w;
    tail[k] = tail[k] + 1;
  endtask

  // Scoreboard.
  typedef struct { logic [11:0] data; logic [1:0] ch; int due; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   pop_log[$];

  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      if (pop_v != 4'b0) begin
        chk($onehot(pop_v) && ((pop_v & empty_v) == 4'b0), "pop_legal",
            {24'b0, pop_v, empty_v}, {24'b0, pop_v, 4'b0});
        for (int k = 0; k < 4; k++)
          if (pop_v[k]) begin
            pop_log.push_back(k);
            sb.push_back('{mem[k][head[k]], 2'(k), cyc + 2});
          end
      end
      if (bus.valid) vcount++;
      if (bus.valid || (sb.size() > 0 && sb[0].due <= cyc)) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_valid", {18'b0, bus.chan, bus.data_out}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk(bus.valid && bus.data_out == e.data && bus.chan == e.ch && e.due == cyc,
              "word_out", {bus.valid, 17'b0, bus.chan, bus.data_out},
              {1'b1, 17'b0, e.ch, e.data});
        end
      end
      if (bus.init)
        while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    end
  end

  // Counter read vectors.
  typedef struct { int phase; logic [1:0] idx; logic [4:0] cnt; } rd_vec_t;
  rd_vec_t vt [20];

  task automatic rd(input logic [1:0] i, input logic [4:0] exp, input string name);
    @(posedge clk); #1;
    bus.req = 1'b1;
    bus.idx = i;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(negedge clk);
    chk(bus.cnt_valid === 1'b1 && bus.contador === exp, name,
        {26'b0, bus.cnt_valid, bus.contador}, {26'b0, 1'b1, exp});
    @(negedge clk);
    chk(bus.cnt_valid === 1'b0 && bus.contador === exp, {name, "_hold"},
        {26'b0, bus.cnt_valid, bus.contador}, {26'b0, 1'b0, exp});
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < 20; i++)
      if (vt[i].phase == p)
        rd(vt[i].idx, vt[i].cnt, $sformatf("cnt_p%0d_i%0d", p, vt[i].idx));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!bus.idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(bus.idle === 1'b1, name, {31'b0, bus.idle}, 32'h1);
  endtask

  task automatic check_order(input int exp_q[$], input string name);
    bit ok;
    ok = (pop_log.size() == exp_q.size());
    for (int i = 0; i < exp_q.size() && ok; i++)
      if (pop_log[i] != exp_q[i]) ok = 1'b0;
    chk(ok, name, pop_log.size(), exp_q.size());
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (pop_log.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk(pop_log.size() >= n, name, pop_log.size(), n);
  endtask

  task automatic check_reset_outs(input string name);
    chk(pop_v == 4'b0 && !bus.valid && bus.data_out == 12'h0 && bus.chan == 2'd0 &&
        bus.contador == 5'd0 && !bus.cnt_valid && !bus.idle, name,
        {pop_v, bus.valid, bus.data_out, bus.chan, bus.contador, bus.cnt_valid, bus.idle}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0;
    int n0;
    int ord[$];

    vt = '{
      '{0, 2'd0, 5'd0}, '{0, 2'd1, 5'd0}, '{0, 2'd2, 5'd0}, '{0, 2'd3, 5'd0},
      '{1, 2'd0, 5'd3}, '{1, 2'd1, 5'd0}, '{1, 2'd2, 5'd3}, '{1, 2'd3, 5'd0},
      '{2, 2'd0, 5'd3}, '{2, 2'd1, 5'd4}, '{2, 2'd2, 5'd3}, '{2, 2'd3, 5'd4},
      '{3, 2'd1, 5'd31}, '{3, 2'd3, 5'd4},
      '{4, 2'd0, 5'd0}, '{4, 2'd1, 5'd0}, '{4, 2'd2, 5'd0}, '{4, 2'd3, 5'd0},
      '{5, 2'd0, 5'd1}, '{5, 2'd3, 5'd1}
    };

    reset     = 1'b0;
    bus.init  = 1'b0;
    bus.stall = 1'b0;
    bus.req   = 1'b1;
    bus.idx   = 2'd2;
    repeat (2) @(negedge clk);
    check_reset_outs("reset_outputs");

    // Reset release followed by an init pulse; all FIFOs empty.
    @(posedge clk); #1;
    reset    = 1'b1;
    bus.req  = 1'b0;
    bus.init = 1'b1;
    @(posedge clk); #1;
    bus.init = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(bus.idle === 1'b1 && pop_v == 4'b0, "idle_after_init", {27'b0, pop_v, bus.idle}, 32'h1);
    run_phase(0);

    // Two channels alternating.
    @(posedge clk); #1;
    pop_log.delete();
    for (int i = 0; i < 3; i++) begin
      load(0, 12'h0A1 + 12'(i));
      load(2, 12'h8B2 + 12'(i));
    end
    wait_idle(40, "idle_after_alt");
    ord = '{0, 2, 0, 2, 0, 2};
    check_order(ord, "order_alt");
    run_phase(1);

    // Stall for four cycles mid-burst.
    @(posedge clk); #1;
    pop_log.delete();
    for (int i = 0; i < 4; i++) begin
      load(1, 12'h401 + 12'(i));
      load(3, 12'hC01 + 12'(i));
    end
    wait_pops(2, 10, "pops_before_stall");
    bus.stall = 1'b1;
    n0  = pop_log.size();
    vc0 = vcount;
    repeat (4) @(posedge clk);
    #1;
    chk(pop_log.size() == n0, "stall_no_pop", pop_log.size(), n0);
    chk(vcount == vc0 + 2, "stall_inflight_out", vcount - vc0, 2);
    bus.stall = 1'b0;
    wait_idle(40, "idle_after_stall");
    ord = '{3, 1, 3, 1, 3, 1, 3, 1};
    check_order(ord, "order_stall");
    run_phase(2);

    // Counter saturation.
    @(posedge clk); #1;
    pop_log.delete();
    for (int i = 0; i < 40; i++) load(1, 12'h400 + 12'(i));
    wait_idle(100, "idle_after_sat");
    chk(pop_log.size() == 40, "sat_pop_count", pop_log.size(), 40);
    run_phase(3);

    // init one cycle after a pop discards the word.
    @(posedge clk); #1;
    pop_log.delete();
    load(0, 12'h0C5);
    vc0 = vcount;
    wait_pops(1, 10, "pop_before_init");
    bus.init = 1'b1;
    @(posedge clk); #1;
    bus.init = 1'b0;
    repeat (4) @(negedge clk);
    chk(vcount == vc0, "init_discard", vcount - vc0, 0);
    wait_idle(20, "idle_after_init2");
    run_phase(4);

    // Pointer restarts at channel 0 after init.
    @(posedge clk); #1;
    pop_log.delete();
    load(3, 12'hC10);
    load(0, 12'h0D1);
    wait_idle(20, "idle_after_ptr");
    ord = '{0, 3};
    check_order(ord, "order_ptr_reset");
    run_phase(5);

`ifdef TL_SINK_CLASS_CHK_EN
    chk(bus.err === 1'b0, "err_before", {31'b0, bus.err}, 32'h0);
    @(posedge clk); #1;
    load(3, 12'h400);
    wait_idle(20, "idle_after_bad");
    chk(bus.err === 1'b1, "err_set", {31'b0, bus.err}, 32'h1);
    repeat (5) @(negedge clk);
    chk(bus.err === 1'b1, "err_sticky", {31'b0, bus.err}, 32'h1);
    rd(2'd3, 5'd1, "cnt_bad_not_counted");
    @(posedge clk); #1;
    bus.init = 1'b1;
    @(posedge clk); #1;
    bus.init = 1'b0;
    @(negedge clk);
    chk(bus.err === 1'b0, "err_cleared", {31'b0, bus.err}, 32'h0);
    wait_idle(10, "idle_after_err");
`endif

    // Asynchronous reset with words in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) load(2, 12'h8C1 + 12'(i));
    begin
      int c;
      c = 0;
      @(negedge clk);
      while (!bus.valid && c < 10) begin
        @(negedge clk);
        c++;
      end
      chk(bus.valid === 1'b1, "valid_before_reset", {31'b0, bus.valid}, 32'h1);
    end
    #2;
    reset = 1'b0;
    #1;
    check_reset_outs("async_reset");
    @(negedge clk);
    check_reset_outs("reset_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tl_sink.md
TL_SINK -- requirements
Module: tl_sink

Interface
REQ-001 The block SHALL provide the following ports: clk, input, 1, rising-edge clock.
REQ-002 The block SHALL provide reset, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL provide data_in0..data_in3, input, 12 each, egress FIFO read data, registered one cycle after pop.
REQ-004 The block SHALL provide empty0..empty3, input, 1 each, egress FIFO empty flags.
REQ-005 The block SHALL provide pop0..pop3, output, 1 each, FIFO read strobes, at most one high per cycle.
REQ-006 The block SHALL provide init, input, 1, clear-and-hold request.
REQ-007 The block SHALL provide stall, input, 1, which blocks issue of new pops.
REQ-008 The block SHALL provide data_out, output, 12, captured word.
REQ-009 The block SHALL provide valid, output, 1, data_out qualifier.
REQ-010 The block SHALL provide chan, output, 2, source channel of data_out.
REQ-011 The block SHALL provide req, input, 1, counter read request.
REQ-012 The block SHALL provide idx, input, 2, counter select.
REQ-013 The block SHALL provide contador, output, 5, counter readout.
REQ-014 The block SHALL provide cnt_valid, output, 1, contador qualifier.
REQ-015 The block SHALL provide idle, output, 1, sink drained and quiescent.
REQ-016 The block SHALL use one clock (clk) and an asynchronous, active-low reset (reset).

Function
REQ-017 The FSM SHALL have four states: RESET, INIT, IDLE and ACTIVE, one-hot or binary-encoded.
REQ-018 Transitions:
- RESET->INIT on the first clk edge after reset deasserts.
- INIT->IDLE when init=0.
- IDLE->ACTIVE when any emptyN=0 and stall=0.
- ACTIVE->IDLE when all emptyN=1 and no pop is in flight.
- Any state->INIT when init=1.
REQ-019 In ACTIVE with stall=0, the block SHALL assert popN for exactly one non-empty channel per cycle.
- Channel selection is round-robin, starting after the last popped channel.
- The pointer starts at channel 0.
REQ-020 A pop issued in cycle t SHALL produce data_out=data_inN, chan=N and valid=1 in cycle t+2, at a sustained throughput of one word per cycle.
REQ-021 popN SHALL never assert while emptyN=1, in any state.
REQ-022 When stall=1, no new pop SHALL issue; in-flight words SHALL still complete per REQ-020.
REQ-023 Each accepted word SHALL increment the 5-bit counter of its channel, saturating at 31 with no wrap.
REQ-024 req=1 in cycle t SHALL produce contador=count[idx] and cnt_valid=1 in cycle t+1.
- cnt_valid lasts one cycle per req cycle.
- contador holds its value while req=0.
REQ-025 A read coinciding with an increment of the same counter SHALL return the pre-increment value.
REQ-026 idle SHALL be 1 only in IDLE state with no pop in flight and valid=0.
REQ-027 Entering INIT SHALL:
- clear all counters;
- discard in-flight words, with no valid;
- deassert all popN;
- reset the round-robin pointer to 0.
REQ-028 req SHALL be serviced in every state except RESET; in RESET, cnt_valid stays 0.

Reset
REQ-029 While reset=0, the block SHALL hold:
- state=RESET;
- popN=0, valid=0, data_out=0, chan=0;
- contador=0, cnt_valid=0, idle=0;
- counters=0, pointer=0.
REQ-030 Reset assertion SHALL take effect immediately, without waiting for clk, and SHALL abort any in-flight word.

Configuration
REQ-031 With TL_SINK_CLASS_CHK_EN defined, the block SHALL add output err, 1 bit, which goes high in the valid cycle when data_out[11:10] differs from chan.
- err is sticky until INIT or reset.
- The offending word still reaches data_out but is not counted.
REQ-032 Without TL_SINK_CLASS_CHK_EN, err SHALL be absent, no class check SHALL be made, and every accepted word SHALL be counted.

Verification
REQ-033 Reset then init pulse, with all empty=1 -> idle=1 by cycle 3, all popN=0 and contador=0 for req on idx 0..3.
REQ-034 Channels 0 and 2 non-empty, 3 words each, with data 0x0A1, 0x8B2 (class check off) -> pops alternate 0,2,0,2,0,2, and valid words appear 2 cycles after each pop in the same order; count[0]=count[2]=3.
REQ-035 Stall=1 asserted mid-burst for 4 cycles -> no pop during stall, the two in-flight words still output, and resume continues from the next channel in round-robin order.
REQ-036 40 words on channel 1 followed by req with idx=1 -> contador=31 and cnt_valid for one cycle.
REQ-037 init=1 one cycle after a pop -> that word is not output and all counters read 0.
REQ-038 With TL_SINK_CLASS_CHK_EN defined, channel 3 receives word 0x400 -> err=1 stays high and count[3] is unchanged.
